riot_bus_master: RTL and testbench

RIOT_BUS_MASTER -- requirements
Module: riot_bus_master

---
 rtl/riot_bus_pkg.sv | 38 +++
 rtl/riot_bus_master.sv | 190 +++++++++++++++++++
 tb/tb_riot_bus_master.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riot_bus_pkg.sv
// ---------------------------------------------------------------------------
// riot_bus_pkg
// Shared definitions for the RIOT (6532-style) bus master:
//   - bus_state_t : FSM state encoding of riot_bus_master
//   - RIOT_*      : register addresses in the I/O/timer space (RS_N = 1)
//   - CS_*        : chip-select encodings for the {CS2_N, CS1} pair
//   - riot_timer_addr() : builds a timer write address from mode and IRQ enable
// ---------------------------------------------------------------------------
package riot_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESP   = 2'd3
    } bus_state_t;

    localparam logic [6:0] RIOT_DRA          = 7'h00;
    localparam logic [6:0] RIOT_DDRA         = 7'h01;
    localparam logic [6:0] RIOT_DRB          = 7'h02;
    localparam logic [6:0] RIOT_DDRB         = 7'h03;
    localparam logic [6:0] RIOT_IRQFLAG      = 7'h05;
    localparam logic [6:0] RIOT_TIMER_BASE   = 7'h14;
    localparam logic [6:0] RIOT_TIMER_IRQ_EN = 7'h08;

    localparam logic [1:0] CS_SELECT   = 2'b01;
    localparam logic [1:0] CS_DESELECT = 2'b10;

    // The timer prescaler mode sits in A[1:0] and the IRQ enable adds 0x08
    // on top of the 0x14 base; none of those bits overlap, so OR is exact.
    function automatic logic [6:0] riot_timer_addr(input logic [1:0] mode,
                                                   input logic       irq_en);
        riot_timer_addr = RIOT_TIMER_BASE
                        | (irq_en ? RIOT_TIMER_IRQ_EN : 7'h00)
                        | {5'b00000, mode};
    endfunction

endpackage

// File: rtl/riot_bus_master.sv
// ---------------------------------------------------------------------------
// riot_bus_master
// Turns single requests into one-cycle RIOT bus accesses, and optionally
// repeats a read (poll) until the read data hits a mask or a read limit is
// reached.
//
// Parameters
//   POLL_GAP : idle cycles between successive poll reads (0..255)
//   POLL_MAX : maximum reads per poll request (1..65535)
//
// Ports
//   CLK, RES                 : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY      : request handshake
//   REQ_WE, REQ_RAM, REQ_POLL: write / RAM space / repeated read
//   REQ_ADDR, REQ_WDATA      : address, write data or poll mask
//   RSP_VALID/RSP_READY      : response handshake
//   RSP_RDATA, RSP_TIMEOUT   : captured read data, poll ended without match
//   R_W, CS, RS_N, A, D_OUT  : RIOT bus outputs
//   D_IN                     : RIOT bus read data (valid during ACCESS)
// ---------------------------------------------------------------------------
module riot_bus_master
    import riot_bus_pkg::*;
#(
    parameter int POLL_GAP = 3,
    parameter int POLL_MAX = 1024
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WE,
    input  logic       REQ_RAM,
    input  logic       REQ_POLL,
    input  logic [6:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic [7:0] RSP_RDATA,
    output logic       RSP_TIMEOUT,
    output logic       R_W,
    output logic [1:0] CS,
    output logic       RS_N,
    output logic [6:0] A,
    output logic [7:0] D_OUT,
    input  logic [7:0] D_IN
);

    localparam logic [7:0]  GAP_LAST   = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    bus_state_t  state;
    bus_state_t  state_next;

    logic        lat_we;
    logic        lat_ram;
    logic        lat_poll;
    logic [6:0]  lat_addr;
    logic [7:0]  lat_wdata;

    logic [7:0]  gap_cnt;
    logic [15:0] poll_cnt;
    logic [7:0]  rdata_q;
    logic        timeout_q;

    logic [15:0] poll_cnt_inc;
    logic        poll_match;
    logic        poll_limit;

    // Poll decisions for the current ACCESS: the count includes this read,
    // and a zero mask can never produce a match.
    always_comb begin
        poll_cnt_inc = poll_cnt + 16'd1;
        poll_match   = (D_IN & lat_wdata) != 8'h00;
        poll_limit   = (poll_cnt_inc == POLL_LIMIT);
    end

    // State register; reset lands in IDLE, which abandons any transaction.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Everything is gated by RES so that the
    // bus is quiet and no handshake is offered during the reset cycles
    // themselves, not just after the first reset edge.
    always_comb begin
        state_next = state;
        REQ_READY  = 1'b0;
        RSP_VALID  = 1'b0;
        R_W        = 1'b1;
        CS         = CS_DESELECT;
        RS_N       = 1'b1;
        A          = 7'h00;
        D_OUT      = 8'h00;

        if (!RES) begin
            case (state)
                ST_IDLE: begin
                    REQ_READY = 1'b1;
                    if (REQ_VALID) begin
                        state_next = ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    CS    = CS_SELECT;
                    RS_N  = ~lat_ram;
                    A     = lat_addr;
                    R_W   = ~lat_we;
                    D_OUT = lat_we ? lat_wdata : 8'h00;
                    if (!lat_poll || poll_match || poll_limit) begin
                        state_next = ST_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_next = ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    RSP_VALID = 1'b1;
                    if (RSP_READY) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Request latch, poll/gap counters and response capture. The poll flag
    // is dropped for writes at acceptance so the rest of the FSM never has
    // to look at WE when deciding whether to repeat. Timeout is recomputed
    // on every ACCESS; only the final one before RESP matters.
    always_ff @(posedge CLK) begin
        if (RES) begin
            lat_we    <= 1'b0;
            lat_ram   <= 1'b0;
            lat_poll  <= 1'b0;
            lat_addr  <= 7'h00;
            lat_wdata <= 8'h00;
            gap_cnt   <= 8'd0;
            poll_cnt  <= 16'd0;
            rdata_q   <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        lat_we    <= REQ_WE;
                        lat_ram   <= REQ_RAM;
                        lat_poll  <= REQ_POLL & ~REQ_WE;
                        lat_addr  <= REQ_ADDR;
                        lat_wdata <= REQ_WDATA;
                        poll_cnt  <= 16'd0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (lat_poll) begin
                        poll_cnt <= poll_cnt_inc;
                    end
                    rdata_q   <= lat_we ? 8'h00 : D_IN;
                    timeout_q <= lat_poll && !poll_match && poll_limit;
                    gap_cnt   <= 8'd0;
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Response fields read as zero while reset is held.
    always_comb begin
        RSP_RDATA   = RES ? 8'h00 : rdata_q;
        RSP_TIMEOUT = RES ? 1'b0  : timeout_q;
    end

endmodule

// File: tb/tb_riot_bus_master.sv
// ---------------------------------------------------------------------------
// tb_riot_bus_master
// Self-checking bench for riot_bus_master with a small RIOT slave model
// (RAM, I/O registers, an IRQ flag that rises after a chosen read count)
// and a transaction-level reference that predicts read count, timing and
// response contents from the protocol rules.
// ---------------------------------------------------------------------------
module tb_riot_bus_master;
    import riot_bus_pkg::*;

    localparam int GAP  = 3;
    localparam int PMAX = 4;

    logic       CLK = 1'b0;
    logic       RES;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_WE;
    logic       REQ_RAM;
    logic       REQ_POLL;
    logic [6:0] REQ_ADDR;
    logic [7:0] REQ_WDATA;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_RDATA;
    logic       RSP_TIMEOUT;
    logic       R_W;
    logic [1:0] CS;
    logic       RS_N;
    logic [6:0] A;
    logic [7:0] D_OUT;
    logic [7:0] D_IN;

    int tests_run    = 0;
    int tests_failed = 0;

    int unsigned cyc = 0;

    logic [7:0] slave_ram [128] = '{default: 8'h00};
    logic [7:0] slave_io  [128] = '{default: 8'h00};
    logic [7:0] ref_ram   [128] = '{default: 8'h00};
    logic [7:0] ref_io    [128] = '{default: 8'h00};

    int irq_reads = 0;
    int irq_base  = 0;
    int irq_fire  = 1;

    int unsigned acc_cyc  [$];
    logic [16:0] acc_info [$];

    riot_bus_master #(
        .POLL_GAP (GAP),
        .POLL_MAX (PMAX)
    ) dut (
        .CLK         (CLK),
        .RES         (RES),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_WE      (REQ_WE),
        .REQ_RAM     (REQ_RAM),
        .REQ_POLL    (REQ_POLL),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .R_W         (R_W),
        .CS          (CS),
        .RS_N        (RS_N),
        .A           (A),
        .D_OUT       (D_OUT),
        .D_IN        (D_IN)
    );

    // Free-running clock and cycle counter.
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
    end

    // Slave read path: RAM, the IRQ flag (bit7 set from the irq_fire-th read
    // of this transaction onwards), or a plain I/O register.
    always_comb begin
        D_IN = 8'h00;
        if (!RS_N) begin
            D_IN = slave_ram[A];
        end else if (A == RIOT_IRQFLAG) begin
            D_IN = ((irq_reads - irq_base + 1) >= irq_fire) ? 8'h80 : 8'h00;
        end else begin
            D_IN = slave_io[A];
        end
    end

    // Slave write path and IRQ flag read counting, on the bus clock edge.
    always @(posedge CLK) begin
        if (CS == 2'b01 && !R_W) begin
            if (!RS_N) begin
                slave_ram[A] <= D_OUT;
            end else begin
                slave_io[A] <= D_OUT;
            end
        end
        if (CS == 2'b01 && R_W && RS_N && A == RIOT_IRQFLAG) begin
            irq_reads <= irq_reads + 1;
        end
    end

    // Bus monitor: log every selected cycle with its cycle number.
    always @(negedge CLK) begin
        if (CS == 2'b01) begin
            acc_cyc.push_back(cyc);
            acc_info.push_back({A, RS_N, R_W, D_OUT});
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Value the slave returns on the k-th read of a transaction.
    function automatic logic [7:0] slaveValue(input logic ram, input logic [6:0] addr,
                                              input int k, input int fire);
        if (ram) return ref_ram[addr];
        if (addr == RIOT_IRQFLAG) return (k >= fire) ? 8'h80 : 8'h00;
        return ref_io[addr];
    endfunction

    // Reference outcome of a request: number of bus reads/writes, response
    // data and timeout flag.
    task automatic predict(input logic we, input logic ram, input logic poll,
                           input logic [6:0] addr, input logic [7:0] wdata, input int fire,
                           output int n, output logic [7:0] data, output logic tmo);
        logic [7:0] v;
        bit         done;
        n    = 1;
        data = 8'h00;
        tmo  = 1'b0;
        if (we) return;
        if (!poll) begin
            data = slaveValue(ram, addr, 1, fire);
            return;
        end
        done = 0;
        for (int k = 1; k <= PMAX && !done; k++) begin
            v = slaveValue(ram, addr, k, fire);
            n = k;
            data = v;
            if ((v & wdata) != 8'h00) done = 1;
        end
        tmo = !done;
    endtask

    // One complete transaction with response held back for 'hold' cycles.
    task automatic applyStimulus(input logic we, input logic ram, input logic poll,
                                 input logic [6:0] addr, input logic [7:0] wdata,
                                 input int fire, input int hold);
        int          n;
        logic [7:0]  exp_data;
        logic        exp_tmo;
        int          base;
        int          seen;
        int unsigned c1;
        int          k;
        bit          got;
        bit          stable;
        logic [16:0] exp_info;

        predict(we, ram, poll, addr, wdata, fire, n, exp_data, exp_tmo);
        if (we) begin
            if (ram) ref_ram[addr] = wdata;
            else     ref_io[addr]  = wdata;
        end

        checkOutput("req_ready_idle", 32'(REQ_READY), 32'd1);
        base      = acc_cyc.size();
        irq_base  = irq_reads;
        irq_fire  = fire;
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_RAM   = ram;
        REQ_POLL  = poll;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        c1  = cyc;
        k   = 1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (RSP_VALID) begin
                got = 1;
            end else begin
                @(posedge CLK);
                #1;
                k++;
            end
        end
        checkOutput("rsp_valid_seen", 32'(got), 32'd1);
        checkOutput("rsp_latency", 32'(k), 32'(2 + (n - 1) * (GAP + 1)));
        checkOutput("rsp_rdata", 32'(RSP_RDATA), 32'(exp_data));
        checkOutput("rsp_timeout", 32'(RSP_TIMEOUT), 32'(exp_tmo));
        checkOutput("req_ready_in_resp", 32'(REQ_READY), 32'd0);
        checkOutput("bus_idle_in_resp", 32'({CS, RS_N, R_W, A, D_OUT}),
                    32'({2'b10, 1'b1, 1'b1, 7'h00, 8'h00}));

        seen = acc_cyc.size() - base;
        checkOutput("access_count", 32'(seen), 32'(n));
        exp_info = {addr, ~ram, ~we, (we ? wdata : 8'h00)};
        for (int i = 0; i < seen && i < n; i++) begin
            checkOutput("access_fields", 32'(acc_info[base + i]), 32'(exp_info));
            checkOutput("access_cycle", 32'(acc_cyc[base + i] - c1 + 1),
                        32'(1 + i * (GAP + 1)));
        end

        if (!got) begin
            RES = 1'b1;
            @(posedge CLK);
            #1;
            RES = 1'b0;
            return;
        end

        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            if (!(RSP_VALID && RSP_RDATA == exp_data && RSP_TIMEOUT == exp_tmo && !REQ_READY))
                stable = 0;
        end
        if (hold > 0) checkOutput("rsp_hold_stable", 32'(stable), 32'd1);

        RSP_READY = 1'b1;
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;
        checkOutput("rsp_released", 32'(RSP_VALID), 32'd0);
        checkOutput("req_ready_after_rsp", 32'(REQ_READY), 32'd1);
    endtask

    // Poll that never matches, interrupted by reset while in the gap.
    task automatic resetDuringGap();
        int  base;
        bit  bad;
        base      = acc_cyc.size();
        irq_base  = irq_reads;
        irq_fire  = 1;
        REQ_VALID = 1'b1;
        REQ_WE    = 1'b0;
        REQ_RAM   = 1'b0;
        REQ_POLL  = 1'b1;
        REQ_ADDR  = RIOT_IRQFLAG;
        REQ_WDATA = 8'h00;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RES = 1'b1;
        #1;
        checkOutput("gaprst_req_ready", 32'(REQ_READY), 32'd0);
        checkOutput("gaprst_rsp", 32'({RSP_VALID, RSP_TIMEOUT, RSP_RDATA}), 32'd0);
        checkOutput("gaprst_bus_idle", 32'({CS, RS_N, R_W, A, D_OUT}),
                    32'({2'b10, 1'b1, 1'b1, 7'h00, 8'h00}));
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RES = 1'b0;
        #1;
        checkOutput("gaprst_ready_after", 32'(REQ_READY), 32'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (RSP_VALID || !REQ_READY) bad = 1;
        end
        checkOutput("gaprst_quiet", 32'(bad), 32'd0);
        checkOutput("gaprst_access_count", 32'(acc_cyc.size() - base), 32'd1);
    endtask

    initial begin
        logic [2:0] kind;
        logic [7:0] mask;

        RES       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WE    = 1'b0;
        REQ_RAM   = 1'b0;
        REQ_POLL  = 1'b0;
        REQ_ADDR  = 7'h00;
        REQ_WDATA = 8'h00;
        RSP_READY = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_req_ready", 32'(REQ_READY), 32'd0);
        checkOutput("reset_rsp", 32'({RSP_VALID, RSP_TIMEOUT, RSP_RDATA}), 32'd0);
        checkOutput("reset_bus_idle", 32'({CS, RS_N, R_W, A, D_OUT}),
                    32'({2'b10, 1'b1, 1'b1, 7'h00, 8'h00}));
        RES = 1'b0;
        #1;
        checkOutput("reset_release_ready", 32'(REQ_READY), 32'd1);

        applyStimulus(1'b1, 1'b0, 1'b0, RIOT_DDRA, 8'hFF, 1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 7'h7F, 8'h55, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'h7F, 8'h00, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, riot_timer_addr(2'b00, 1'b0), 8'h03, 1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, riot_timer_addr(2'b11, 1'b1), 8'h10, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, RIOT_IRQFLAG, 8'h80, 3, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, RIOT_IRQFLAG, 8'h00, 1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 7'h7F, 8'h00, 1, 10);
        applyStimulus(1'b1, 1'b0, 1'b1, RIOT_DRB, 8'hA5, 1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, RIOT_DRB, 8'h00, 1, 0);
        resetDuringGap();

        for (int t = 0; t < 40; t++) begin
            kind = 3'($urandom_range(0, 5));
            mask = 8'($urandom);
            case (kind)
                3'd0: applyStimulus(1'b1, 1'b1, 1'($urandom), 7'($urandom), 8'($urandom), 1,
                                    $urandom_range(0, 3));
                3'd1: applyStimulus(1'b0, 1'b1, 1'b0, 7'($urandom), 8'h00, 1,
                                    $urandom_range(0, 3));
                3'd2: applyStimulus(1'b1, 1'b0, 1'($urandom), 7'($urandom_range(0, 3)),
                                    8'($urandom), 1, $urandom_range(0, 3));
                3'd3: applyStimulus(1'b0, 1'b0, 1'b0, 7'($urandom_range(0, 3)), 8'h00, 1,
                                    $urandom_range(0, 3));
                3'd4: applyStimulus(1'b0, 1'b0, 1'b1, RIOT_IRQFLAG,
                                    ($urandom_range(0, 2) == 0) ? 8'h00 : (mask | 8'h80),
                                    $urandom_range(1, 6), $urandom_range(0, 3));
                default: applyStimulus(1'b0, 1'b1, 1'b1, 7'($urandom), mask, 1,
                                       $urandom_range(0, 3));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
